sata_link_mgr: RTL

SATA_LINK_MGR -- requirements
Module: sata_link_mgr

---
 rtl/sata_link_mgr_pkg.sv | 30 +++
 rtl/sata_link_mgr_if.sv | 24 ++
 rtl/sata_link_mgr_link_timer.sv | 26 ++
 rtl/sata_link_mgr.sv | 136 +++++++++++++
 4 files changed

// File: rtl/sata_link_mgr_pkg.sv
// Shared SATA host definitions: link manager states and DET command/status codes.
package sata_link_mgr_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_GTX  = 3'd0,
        ST_WAIT_LINK = 3'd1,
        ST_UP        = 3'd2,
        ST_BACKOFF   = 3'd3,
        ST_OFFLINE   = 3'd4,
        ST_FAILED    = 3'd5
    } link_state_e;

    localparam logic [3:0] DET_CMD_COMRESET = 4'd1;
    localparam logic [3:0] DET_CMD_OFFLINE  = 4'd4;

    localparam logic [3:0] DET_STS_NONE    = 4'd0;
    localparam logic [3:0] DET_STS_PRESENT = 4'd1;
    localparam logic [3:0] DET_STS_PHY_UP  = 4'd3;
    localparam logic [3:0] DET_STS_OFFLINE = 4'd4;

    function automatic logic [3:0] det_status_of(input link_state_e s);
        case (s)
            ST_WAIT_LINK, ST_BACKOFF: det_status_of = DET_STS_PRESENT;
            ST_UP:                    det_status_of = DET_STS_PHY_UP;
            ST_OFFLINE:               det_status_of = DET_STS_OFFLINE;
            default:                  det_status_of = DET_STS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sata_link_mgr_if.sv
// Host-side control/status bundle between the SATA link manager and its user.
interface sata_link_mgr_if;
    logic       gtx_ready;
    logic       phy_ready;
    logic [3:0] det_cmd;
    logic       det_cmd_we;
    logic       set_offline;
    logic       comreset_send;
    logic [3:0] det_status;
    logic [2:0] retry_cnt;
    logic       link_fail;
    logic       link_lost;
    logic       busy;

    modport master (
        output gtx_ready, phy_ready, det_cmd, det_cmd_we,
        input  set_offline, comreset_send, det_status, retry_cnt, link_fail, link_lost, busy
    );

    modport slave (
        input  gtx_ready, phy_ready, det_cmd, det_cmd_we,
        output set_offline, comreset_send, det_status, retry_cnt, link_fail, link_lost, busy
    );
endinterface

// File: rtl/sata_link_mgr_link_timer.sv
// Loadable down-counter shared by the link-wait and backoff intervals; expired at zero.
module link_timer #(
    parameter int               WIDTH   = 17,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= RST_VAL;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/sata_link_mgr.sv
// SATA link manager: sequences COMRESET/offline around transceiver and OOB link state,
// with timed link waits, backoff between retries and a sticky failure flag.
module sata_link_mgr
    import sata_link_mgr_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int BACKOFF_CYCLES = 1024,
    parameter int RETRY_MAX      = 7
) (
    input  logic           clk,
    input  logic           rst,
    sata_link_mgr_if.slave link
);

    localparam int TMAX = (TIMEOUT_CYCLES > BACKOFF_CYCLES) ? TIMEOUT_CYCLES : BACKOFF_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    // Loads are N-1 so expiry lands on the N-th cycle in the state.
    localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] B_LOAD = TW'(BACKOFF_CYCLES - 1);
    localparam logic [2:0]    RMAX   = 3'(RETRY_MAX);

    link_state_e state, state_nxt;
    logic [2:0]  retry_q, retry_nxt;
    logic        fail_q, fail_nxt;
    logic        off_q, off_nxt;
    logic        cr_q, cr_nxt;
    logic        lost_q, lost_nxt;
    logic [3:0]  det_status_q;
    logic        busy_q;

    logic        cmd_comreset, cmd_offline, gtx_lost;
    logic        tmr_load, tmr_expired;
    logic [TW-1:0] tmr_val;

    assign cmd_comreset = link.det_cmd_we && (link.det_cmd == DET_CMD_COMRESET);
    assign cmd_offline  = link.det_cmd_we && (link.det_cmd == DET_CMD_OFFLINE);
    assign gtx_lost     = !link.gtx_ready && (state != ST_OFFLINE) && (state != ST_FAILED);

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_q;
        fail_nxt  = fail_q;
        off_nxt   = 1'b0;
        cr_nxt    = 1'b0;
        lost_nxt  = 1'b0;
        if (cmd_comreset) begin
            state_nxt = ST_WAIT_LINK;
            cr_nxt    = 1'b1;
            retry_nxt = 3'd0;
            fail_nxt  = 1'b0;
        end else if (cmd_offline) begin
            state_nxt = ST_OFFLINE;
            off_nxt   = 1'b1;
        end else if (gtx_lost) begin
            state_nxt = ST_WAIT_GTX;
        end else begin
            case (state)
                ST_WAIT_GTX:
                    if (link.gtx_ready) state_nxt = ST_WAIT_LINK;
                ST_WAIT_LINK:
                    if (link.phy_ready) begin
                        state_nxt = ST_UP;
                        retry_nxt = 3'd0;
                    end else if (tmr_expired) begin
                        if (retry_q >= RMAX) begin
                            state_nxt = ST_FAILED;
                            fail_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_BACKOFF;
                            retry_nxt = retry_q + 3'd1;
                            off_nxt   = 1'b1;
                        end
                    end
                ST_UP:
                    if (!link.phy_ready) begin
                        state_nxt = ST_BACKOFF;
                        lost_nxt  = 1'b1;
                        off_nxt   = 1'b1;
                    end
                ST_BACKOFF:
                    if (tmr_expired) begin
                        state_nxt = ST_WAIT_LINK;
                        cr_nxt    = 1'b1;
                    end
                default: ;
            endcase
        end
    end

    // Reload on every entry into a timed state; a COMRESET inside WAIT_LINK restarts the wait.
    assign tmr_load = ((state_nxt == ST_WAIT_LINK) && ((state != ST_WAIT_LINK) || cmd_comreset)) ||
                      ((state_nxt == ST_BACKOFF) && (state != ST_BACKOFF));
    assign tmr_val  = (state_nxt == ST_BACKOFF) ? B_LOAD : T_LOAD;

    link_timer #(
        .WIDTH   (TW),
        .RST_VAL (T_LOAD)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_WAIT_GTX;
            retry_q      <= 3'd0;
            fail_q       <= 1'b0;
            off_q        <= 1'b0;
            cr_q         <= 1'b0;
            lost_q       <= 1'b0;
            det_status_q <= DET_STS_NONE;
            busy_q       <= 1'b0;
        end else begin
            state        <= state_nxt;
            retry_q      <= retry_nxt;
            fail_q       <= fail_nxt;
            off_q        <= off_nxt;
            cr_q         <= cr_nxt;
            lost_q       <= lost_nxt;
            det_status_q <= det_status_of(state_nxt);
            busy_q       <= (state_nxt == ST_WAIT_LINK) || (state_nxt == ST_BACKOFF);
        end
    end

    assign link.set_offline   = off_q;
    assign link.comreset_send = cr_q;
    assign link.det_status    = det_status_q;
    assign link.retry_cnt     = retry_q;
    assign link.link_fail     = fail_q;
    assign link.link_lost     = lost_q;
    assign link.busy          = busy_q;

endmodule
